// File: rtl/hue_wheel_fader.sv
// Hue-wheel fader: sweeps hue over six segments and drives scaled R/G/B PWM duty values.
// Latency: duty/segment/hue_wrap are registered one clk after the seg/step/brightness they reflect.
// Backpressure: none; run=0 freezes the prescaler and hue position, outputs keep tracking brightness.
module hue_wheel_fader #(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEPS        = 100,
  parameter int INTERVAL_W   = 16,
  parameter int BRIGHT_W     = 8,
  parameter int DUTY_W       = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  reverse,
  input  logic [INTERVAL_W-1:0] step_interval,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [DUTY_W-1:0]     red_pwm_value,
  output logic [DUTY_W-1:0]     green_pwm_value,
  output logic [DUTY_W-1:0]     blue_pwm_value,
  output logic [2:0]            segment,
  output logic                  hue_wrap
);

  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PROD_W = DUTY_W + BRIGHT_W + 1;

  localparam logic [DUTY_W-1:0] FULL     = DUTY_W'(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] INC      = DUTY_W'(PWM_INTERVAL / STEPS);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEPS - 1);

  // A non-integer step increment would break segment continuity, so refuse to build.
  generate
    if ((PWM_INTERVAL % STEPS) != 0) begin : g_bad_steps
      $error("hue_wheel_fader: PWM_INTERVAL must be divisible by STEPS");
    end
  endgenerate

  logic [INTERVAL_W-1:0] r_pcnt;
  logic [2:0]            r_seg;
  logic [STEP_W-1:0]     r_step;
  logic                  r_wrap_pend;

  logic [INTERVAL_W-1:0] w_iv_m1;
  logic                  w_tick;
  logic [INTERVAL_W-1:0] w_pcnt_nxt;
  logic [2:0]            w_seg_nxt;
  logic [STEP_W-1:0]     w_step_nxt;
  logic                  w_wrap;
  logic [DUTY_W-1:0]     w_up;
  logic [DUTY_W-1:0]     w_dn;
  logic [DUTY_W-1:0]     w_raw_r;
  logic [DUTY_W-1:0]     w_raw_g;
  logic [DUTY_W-1:0]     w_raw_b;
  logic [BRIGHT_W:0]     w_bmul;

  // Scale a raw level by (brightness+1)/2^BRIGHT_W; product is wide enough never to overflow.
  function automatic logic [DUTY_W-1:0] scale(input logic [DUTY_W-1:0] raw,
                                              input logic [BRIGHT_W:0] mul);
    logic [PROD_W-1:0] p;
    p = PROD_W'(raw) * PROD_W'(mul);
    return DUTY_W'(p >> BRIGHT_W);
  endfunction

  // Prescaler: >= compare lets a shrinking interval take effect immediately.
  always_comb begin
    w_iv_m1    = (step_interval == '0) ? '0 : (step_interval - INTERVAL_W'(1));
    w_tick     = 1'b0;
    w_pcnt_nxt = r_pcnt;
    if (run) begin
      if (r_pcnt >= w_iv_m1) begin
        w_tick     = 1'b1;
        w_pcnt_nxt = '0;
      end else begin
        w_pcnt_nxt = r_pcnt + INTERVAL_W'(1);
      end
    end
  end

  // Hue position advance; direction is sampled per tick so the path stays continuous.
  always_comb begin
    w_step_nxt = r_step;
    w_seg_nxt  = r_seg;
    w_wrap     = 1'b0;
    if (w_tick) begin
      if (!reverse) begin
        if (r_step == STEP_MAX) begin
          w_step_nxt = '0;
          if (r_seg == 3'd5) begin
            w_seg_nxt = 3'd0;
            w_wrap    = 1'b1;
          end else begin
            w_seg_nxt = r_seg + 3'd1;
          end
        end else begin
          w_step_nxt = r_step + STEP_W'(1);
        end
      end else begin
        if (r_step == '0) begin
          w_step_nxt = STEP_MAX;
          if (r_seg == 3'd0) begin
            w_seg_nxt = 3'd5;
            w_wrap    = 1'b1;
          end else begin
            w_seg_nxt = r_seg - 3'd1;
          end
        end else begin
          w_step_nxt = r_step - STEP_W'(1);
        end
      end
    end
  end

  // Raw per-channel level from the current segment and step.
  always_comb begin
    w_up    = DUTY_W'(r_step) * INC;
    w_dn    = FULL - w_up;
    w_raw_r = '0;
    w_raw_g = '0;
    w_raw_b = '0;
    case (r_seg)
      3'd0: begin w_raw_r = FULL; w_raw_g = w_up; end
      3'd1: begin w_raw_r = w_dn; w_raw_g = FULL; end
      3'd2: begin w_raw_g = FULL; w_raw_b = w_up; end
      3'd3: begin w_raw_g = w_dn; w_raw_b = FULL; end
      3'd4: begin w_raw_r = w_up; w_raw_b = FULL; end
      3'd5: begin w_raw_r = FULL; w_raw_b = w_dn; end
      default: ;
    endcase
    w_bmul = {1'b0, brightness} + (BRIGHT_W + 1)'(1);
  end

  // Position state; the wrap flag is staged so it lines up with the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt      <= '0;
      r_seg       <= 3'd0;
      r_step      <= '0;
      r_wrap_pend <= 1'b0;
    end else begin
      r_pcnt      <= w_pcnt_nxt;
      r_seg       <= w_seg_nxt;
      r_step      <= w_step_nxt;
      r_wrap_pend <= w_wrap;
    end
  end

  // Output registers: scaled duties, segment and wrap pulse all update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      red_pwm_value   <= '0;
      green_pwm_value <= '0;
      blue_pwm_value  <= '0;
      segment         <= 3'd0;
      hue_wrap        <= 1'b0;
    end else begin
      red_pwm_value   <= scale(w_raw_r, w_bmul);
      green_pwm_value <= scale(w_raw_g, w_bmul);
      blue_pwm_value  <= scale(w_raw_b, w_bmul);
      segment         <= r_seg;
      hue_wrap        <= r_wrap_pend;
    end
  end

endmodule

// File: tb/tb_hue_wheel_fader.sv
// Directed bench for hue_wheel_fader at PWM_INTERVAL=1200, STEPS=100, BRIGHT_W=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_hue_wheel_fader;

  logic        clk;
  logic        reset;
  logic        run;
  logic        reverse;
  logic [15:0] step_interval;
  logic [7:0]  brightness;
  logic [10:0] red_pwm_value;
  logic [10:0] green_pwm_value;
  logic [10:0] blue_pwm_value;
  logic [2:0]  segment;
  logic        hue_wrap;

  int n_checks = 0;
  int n_errors = 0;

  hue_wheel_fader #(
    .PWM_INTERVAL(1200),
    .STEPS       (100),
    .INTERVAL_W  (16),
    .BRIGHT_W    (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .reverse        (reverse),
    .step_interval  (step_interval),
    .brightness     (brightness),
    .red_pwm_value  (red_pwm_value),
    .green_pwm_value(green_pwm_value),
    .blue_pwm_value (blue_pwm_value),
    .segment        (segment),
    .hue_wrap       (hue_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    edges(1);
    reset = 1'b0;
  endtask

  task automatic check_rgb(input string tag, input int r, input int g, input int b);
    check_eq({tag, "_r"}, 32'(red_pwm_value),   32'(r));
    check_eq({tag, "_g"}, 32'(green_pwm_value), 32'(g));
    check_eq({tag, "_b"}, 32'(blue_pwm_value),  32'(b));
  endtask

  initial begin
    int wrap_cnt;
    int wrap_at;
    int max_sum;
    int max_ch;
    int s;

    reset = 1'b1; run = 1'b0; reverse = 1'b0;
    step_interval = 16'd4; brightness = 8'd255;
    edges(2);

    // 1. reset state, then slow forward sweep at interval 4
    run = 1'b1;
    do_reset();
    check_rgb("rst", 0, 0, 0);
    check_eq("rst_seg", 32'(segment), 0);
    check_eq("rst_wrap", 32'(hue_wrap), 0);
    edges(1);
    check_rgb("t1_first", 1200, 0, 0);
    check_eq("t1_first_seg", 32'(segment), 0);
    edges(40);
    check_rgb("t1_10ticks", 1200, 120, 0);
    edges(360);
    check_rgb("t1_100ticks", 1200, 1200, 0);
    check_eq("t1_100ticks_seg", 32'(segment), 1);

    // 2. full forward sweep at interval 1
    step_interval = 16'd1;
    do_reset();
    wrap_cnt = 0; wrap_at = -1; max_sum = 0; max_ch = 0;
    for (int i = 1; i <= 605; i++) begin
      edges(1);
      if (hue_wrap) begin
        wrap_cnt++;
        wrap_at = i;
      end
      s = int'(red_pwm_value) + int'(green_pwm_value) + int'(blue_pwm_value);
      if (s > max_sum) max_sum = s;
      if (int'(red_pwm_value)   > max_ch) max_ch = int'(red_pwm_value);
      if (int'(green_pwm_value) > max_ch) max_ch = int'(green_pwm_value);
      if (int'(blue_pwm_value)  > max_ch) max_ch = int'(blue_pwm_value);
      if (i == 601) check_eq("t2_seg_at_wrap", 32'(segment), 0);
    end
    check_eq("t2_wrap_cycles", 32'(wrap_cnt), 1);
    check_eq("t2_wrap_edge", 32'(wrap_at), 601);
    check_eq("t2_max_sum", 32'(max_sum), 2400);
    check_eq("t2_max_ch", 32'(max_ch), 1200);

    // 3. reverse from reset, then flip back to forward
    reverse = 1'b1;
    do_reset();
    edges(1);
    run = 1'b0;
    edges(1);
    check_rgb("t3_rev_first", 1200, 0, 12);
    check_eq("t3_rev_seg", 32'(segment), 5);
    check_eq("t3_rev_wrap", 32'(hue_wrap), 1);
    reverse = 1'b0;
    run = 1'b1;
    edges(1);
    run = 1'b0;
    check_eq("t3_hold_wrap", 32'(hue_wrap), 0);
    edges(1);
    check_rgb("t3_back_fwd", 1200, 0, 0);
    check_eq("t3_back_seg", 32'(segment), 0);
    check_eq("t3_back_wrap", 32'(hue_wrap), 1);

    // 4. pause, zero interval, runtime interval shrink
    run = 1'b1;
    step_interval = 16'd4;
    do_reset();
    edges(6);
    run = 1'b0;
    edges(50);
    check_rgb("t4_paused", 1200, 12, 0);
    run = 1'b1;
    edges(2);
    check_eq("t4_resume_hold", 32'(green_pwm_value), 12);
    edges(1);
    check_eq("t4_resume_step", 32'(green_pwm_value), 24);
    step_interval = 16'd0;
    edges(2);
    check_eq("t4_iv0_a", 32'(green_pwm_value), 36);
    edges(1);
    check_eq("t4_iv0_b", 32'(green_pwm_value), 48);
    step_interval = 16'd1000;
    edges(500);
    check_eq("t4_iv1000", 32'(green_pwm_value), 60);
    step_interval = 16'd3;
    edges(2);
    check_eq("t4_shrink_tick", 32'(green_pwm_value), 72);
    edges(2);
    check_eq("t4_shrink_wait", 32'(green_pwm_value), 72);
    edges(1);
    check_eq("t4_shrink_next", 32'(green_pwm_value), 84);

    // 5. brightness scaling at seg0 step50
    run = 1'b1;
    step_interval = 16'd1;
    do_reset();
    edges(50);
    run = 1'b0;
    edges(1);
    check_rgb("t5_raw", 1200, 600, 0);
    brightness = 8'd127;
    edges(1);
    check_rgb("t5_b127", 600, 300, 0);
    brightness = 8'd0;
    edges(1);
    check_rgb("t5_b0", 4, 2, 0);
    brightness = 8'd255;
    edges(1);
    check_rgb("t5_b255", 1200, 600, 0);

    // 6. reset in the middle of seg3 step40
    run = 1'b1;
    do_reset();
    edges(340);
    run = 1'b0;
    edges(1);
    check_rgb("t6_pre", 0, 720, 1200);
    check_eq("t6_pre_seg", 32'(segment), 3);
    reset = 1'b1;
    edges(1);
    reset = 1'b0;
    check_rgb("t6_rst", 0, 0, 0);
    check_eq("t6_rst_seg", 32'(segment), 0);
    check_eq("t6_rst_wrap", 32'(hue_wrap), 0);
    edges(1);
    check_rgb("t6_after", 1200, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hue_wheel_fader.md
Name: hue_wheel_fader

Overview:
- Parametrised successor to the single-speed RGB colour-wheel fader.
- Sweeps hue through six 60° segments and drives three PWM duty values, one each for R, G and B.
- Adds the following over the previous generation:
  - runtime step interval
  - pause
  - reverse direction
  - global brightness scaling
  - wrap sync pulse
- Everything runs in one clock domain using enable strobes. No derived clocks.
- Sits between the control/register logic and the three per-channel PWM generators.

Parameters:
- PWM_INTERVAL, 1200: full-scale duty value (PWM period in clk cycles).
- STEPS, 100: steps per 60° segment. PWM_INTERVAL must be divisible by STEPS; elaboration fails otherwise.
- INTERVAL_W, 16: width of the step_interval input.
- BRIGHT_W, 8: width of the brightness input.
- DUTY_W, $clog2(PWM_INTERVAL+1): width of the duty outputs.

Ports:
- clk  in  1  system clock (12 MHz).
- reset  in  1  synchronous, active-high.
- run  in  1  1 = advance hue on ticks; 0 = hold.
- reverse  in  1  0 = R→Y→G→C→B→P; 1 = opposite direction.
- step_interval  in  INTERVAL_W  clk cycles per step; a value of 0 is treated as 1.
- brightness  in  BRIGHT_W  global scale.
- red_pwm_value  out  DUTY_W  red duty.
- green_pwm_value  out  DUTY_W  green duty.
- blue_pwm_value  out  DUTY_W  blue duty.
- segment  out  3  current segment, 0..5.
- hue_wrap  out  1  one-cycle pulse when the hue wraps.

Behaviour:
- Internal state:
  - prescaler `pcnt` (INTERVAL_W bits)
  - `seg` (0..5)
  - `step` (0..STEPS-1)
- Reset (synchronous, highest priority):
  - pcnt=0, seg=0, step=0.
  - All duty outputs = 0, hue_wrap = 0.
  - Reset mid-sweep discards position. Every output is 0 in the cycle after reset is sampled.
- Prescaler:
  - Let iv = max(step_interval, 1).
  - If run=0: pcnt holds and no tick is issued.
  - Else, if pcnt >= iv-1: pcnt ← 0 and tick=1.
    - The >= comparison makes a runtime shrink of the interval take effect at once, with no long wrap.
  - Else: pcnt ← pcnt+1.
- Step advance on tick, forward (reverse=0):
  - step ← step+1.
  - At STEPS-1: step ← 0 and seg ← seg+1, with 5 wrapping to 0.
- Step advance on tick, reverse (reverse=1):
  - step ← step-1.
  - At 0: step ← STEPS-1 and seg ← seg-1, with 0 wrapping to 5.
- Changing reverse takes effect on the next tick with no glitch: the position is continuous.
- hue_wrap:
  - Asserted for one cycle, coincident with the updated outputs, when the transition crosses the seg5/seg0 boundary, in either direction.
  - Low otherwise.
- Raw level, with INC = PWM_INTERVAL/STEPS, F = PWM_INTERVAL, up = step*INC, dn = F - step*INC:
  - seg0: R=F, G=up, B=0
  - seg1: R=dn, G=F, B=0
  - seg2: R=0, G=F, B=up
  - seg3: R=0, G=dn, B=F
  - seg4: R=up, G=0, B=F
  - seg5: R=F, G=0, B=dn
  - The sweep is continuous across boundaries: the end of a segment plus one step equals the start of the next.
- Scaling:
  - duty = (raw * (brightness+1)) >> BRIGHT_W.
  - The product is computed at full width (DUTY_W+BRIGHT_W+1 bits); no overflow is permitted.
  - brightness = all-ones gives duty = raw exactly. brightness = 0 gives raw>>BRIGHT_W.
- Latency:
  - Duty outputs are registered from current seg/step/brightness: one clk of latency.
  - A brightness change is visible on the cycle after it is sampled, independent of ticks.
- segment output equals `seg`, registered alongside the duty outputs.
- Duty values never exceed PWM_INTERVAL.

Test Plan (PWM_INTERVAL=1200, STEPS=100, BRIGHT_W=8, brightness=255 unless noted):
1. Reset, then run=1, step_interval=4:
   - Cycle after reset released: R=1200, G=0, B=0, segment=0.
   - After 10 ticks (40 clk): G=120.
   - After 100 ticks: segment=1, R=1200, G=1200.
2. Full forward sweep, step_interval=1:
   - After 600 ticks: segment back to 0 and hue_wrap pulses exactly once, for 1 cycle.
   - R+G+B peak never exceeds 2400; each channel stays ≤ 1200 throughout.
3. Reverse from reset, step_interval=1, reverse=1:
   - First tick gives seg=5, step=99: R=1200, G=0, B=12.
   - hue_wrap pulses.
   - Toggle reverse back: the next tick returns to seg0/step0.
4. Pause and interval change:
   - run=0 for 50 cycles: outputs and pcnt frozen.
   - step_interval=0 behaves as 1.
   - Change step_interval from 1000 to 3 while pcnt=500: a tick occurs on the next cycle, then every 3 cycles.
5. Brightness:
   - seg0, step 50 (G raw=600), brightness=127: R=600, G=300.
   - brightness=0: R=4, G=2.
   - Restore to 255 → exact raw values, one cycle later.
6. Mid-sweep reset at seg3, step 40, asserted for 1 cycle:
   - Next cycle: all duties 0, segment=0, hue_wrap=0.
   - Then R=1200, G=0, B=0.
